// File: rtl/lag_tile_inject_arbiter_pkg.sv
// Shared types and width helpers for the tile injection arbiter and its
// cyclic priority picker.
package LAG_inject_pkg;

  // Width of an index field; never narrower than one bit.
  function automatic int clog2w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int DW_DEF   = 32;
  localparam int NPLE_DEF = 2;
  localparam int PLW_DEF  = clog2w(NPLE_DEF);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } inj_state_t;

  // Flit layout at the default widths; parameterised modules declare the
  // same layout locally with their own widths.
  typedef struct packed {
    logic               head;
    logic               tail;
    logic [PLW_DEF-1:0] pl;
    logic [DW_DEF-1:0]  data;
  } inj_flit_t;

endpackage

// File: rtl/lag_tile_inject_arbiter_rr_pick.sv
// Combinational cyclic priority picker: first set request at or after ptr,
// wrapping modulo N (N need not be a power of two).
module lag_rr_pick
  import LAG_inject_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = clog2w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] gnt_idx,
  output logic          any
);

  int w_j;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    gnt_idx = '0;
    any     = 1'b0;
    w_j     = 0;
    for (int k = 0; k < N; k++) begin
      w_j = int'(ptr) + k;
      if (w_j >= N) w_j = w_j - N;
      if (!any && req[w_j]) begin
        any     = 1'b1;
        gnt_idx = PW'(w_j);
      end
    end
  end

endmodule

// File: rtl/lag_tile_inject_arbiter.sv
// Packet-granular round-robin arbiter sharing one tile injection lane among
// NSRC sources, with a registered output flit and per-PL back-pressure.
module lag_tile_inject_arbiter
  import LAG_inject_pkg::*;
#(
  parameter int NSRC    = 4,
  parameter int DW      = 32,
  parameter int NPLE    = 2,
  parameter int MAX_LEN = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NSRC-1:0]               src_valid,
  input  logic [NSRC-1:0]               src_head,
  input  logic [NSRC-1:0]               src_tail,
  input  logic [NSRC*clog2w(NPLE)-1:0]  src_pl,
  input  logic [NSRC*DW-1:0]            src_data,
  output logic [NSRC-1:0]               src_ready,
  input  logic [NPLE-1:0]               full_in,
  output logic                          out_valid,
  output logic                          out_head,
  output logic                          out_tail,
  output logic [clog2w(NPLE)-1:0]       out_pl,
  output logic [DW-1:0]                 out_data,
  output logic [clog2w(NSRC)-1:0]       out_src,
  output logic                          err_len
);

  localparam int PLW = clog2w(NPLE);
  localparam int SW  = clog2w(NSRC);
  localparam int LW  = clog2w(MAX_LEN + 1);

  inj_state_t      r_state, w_next_state;
  logic [SW-1:0]   r_rr_ptr, r_out_src, w_sel, w_pick_idx;
  logic [LW-1:0]   r_len_cnt, w_flit_num;
  logic [NSRC-1:0] w_elig, w_ready;
  logic            w_pick_any, w_consume, w_drain, w_load, w_force, w_release;
  logic            r_out_valid, r_out_head, r_out_tail, r_err_len;
  logic [PLW-1:0]  r_out_pl;
  logic [DW-1:0]   r_out_data;

  assign w_elig    = src_valid & src_head;
  assign w_consume = r_out_valid && !full_in[r_out_pl];
  assign w_drain   = !r_out_valid || w_consume;

  lag_rr_pick #(.N(NSRC)) u_pick (
    .req     (w_elig),
    .ptr     (r_rr_ptr),
    .gnt_idx (w_pick_idx),
    .any     (w_pick_any)
  );

  always_comb begin
    w_next_state = r_state;
    w_sel        = r_out_src;
    w_ready      = '0;
    w_load       = 1'b0;
    w_flit_num   = r_len_cnt + LW'(1);
    // Nothing is acknowledged while reset is held.
    if (!rst) begin
      unique case (r_state)
        IDLE: if (w_pick_any && w_drain) begin
          w_sel        = w_pick_idx;
          w_load       = 1'b1;
          w_flit_num   = LW'(1);
          w_next_state = LOCK;
        end
        LOCK: if (src_valid[r_out_src] && w_drain) w_load = 1'b1;
      endcase
      if (w_load) w_ready[w_sel] = 1'b1;
    end
    w_force   = w_load && !src_tail[w_sel] && (w_flit_num == LW'(MAX_LEN));
    w_release = w_load && (src_tail[w_sel] || w_force);
    if (w_release) w_next_state = IDLE;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_head  <= 1'b0;
      r_out_tail  <= 1'b0;
      r_out_pl    <= '0;
      r_out_data  <= '0;
      r_out_src   <= '0;
      r_err_len   <= 1'b0;
      r_rr_ptr    <= '0;
      r_len_cnt   <= '0;
    end else begin
      // A load in the same cycle as a consume overwrites with no bubble.
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_head  <= src_head[w_sel];
        r_out_tail  <= src_tail[w_sel] | w_force;
        r_out_data  <= src_data[w_sel*DW +: DW];
        if (r_state == IDLE) begin
          r_out_pl  <= src_pl[w_sel*PLW +: PLW];
          r_out_src <= w_sel;
        end
      end else if (w_consume) begin
        r_out_valid <= 1'b0;
      end
      if (w_release) begin
        r_len_cnt <= '0;
        r_rr_ptr  <= (w_sel == SW'(NSRC - 1)) ? '0 : w_sel + 1'b1;
      end else if (w_load) begin
        r_len_cnt <= w_flit_num;
      end
      if (w_force) r_err_len <= 1'b1;
    end
  end

  assign src_ready = w_ready;
  assign out_valid = r_out_valid;
  assign out_head  = r_out_head;
  assign out_tail  = r_out_tail;
  assign out_pl    = r_out_pl;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;
  assign err_len   = r_err_len;

endmodule

// File: tb/tb_lag_tile_inject_arbiter.sv
// Directed table-driven bench for lag_tile_inject_arbiter (NSRC=4, MAX_LEN=4).
module tb_lag_tile_inject_arbiter;
  import LAG_inject_pkg::*;

  localparam int NSRC    = 4;
  localparam int DW      = 32;
  localparam int NPLE    = 2;
  localparam int MAX_LEN = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      src_valid, src_head, src_tail, src_pl, src_ready;
  logic [127:0]    src_data;
  logic [1:0]      full_in;
  logic            out_valid, out_head, out_tail, err_len;
  logic [0:0]      out_pl;
  logic [31:0]     out_data;
  logic [1:0]      out_src;

  always #5 clk = ~clk;

  lag_tile_inject_arbiter #(
    .NSRC(NSRC), .DW(DW), .NPLE(NPLE), .MAX_LEN(MAX_LEN)
  ) dut (
    .clk(clk), .rst(rst),
    .src_valid(src_valid), .src_head(src_head), .src_tail(src_tail),
    .src_pl(src_pl), .src_data(src_data), .src_ready(src_ready),
    .full_in(full_in),
    .out_valid(out_valid), .out_head(out_head), .out_tail(out_tail),
    .out_pl(out_pl), .out_data(out_data), .out_src(out_src),
    .err_len(err_len)
  );

  // Inputs for one cycle plus the expected ready (during the cycle) and the
  // expected registered outputs (after the edge). Source i sends {tag,16'h0,i}.
  typedef struct {
    logic       rst;
    logic [3:0] valid, head, tail, pl;
    logic [1:0] full;
    logic [7:0] tag;
    logic [3:0] e_ready;
    logic       e_valid, e_head, e_tail, e_pl;
    logic [1:0] e_src;
    logic [7:0] e_tag;
    logic       e_err;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;
  vec_t tbl[$];

  function automatic vec_t mk(
    input logic r, input logic [3:0] v, h, t, p, input logic [1:0] f,
    input logic [7:0] tg, input logic [3:0] er, input logic ev, eh, et, ep,
    input logic [1:0] es, input logic [7:0] etg, input logic ee);
    vec_t x;
    x.rst = r; x.valid = v; x.head = h; x.tail = t; x.pl = p; x.full = f;
    x.tag = tg; x.e_ready = er; x.e_valid = ev; x.e_head = eh; x.e_tail = et;
    x.e_pl = ep; x.e_src = es; x.e_tag = etg; x.e_err = ee;
    return x;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string id);
    inj_flit_t obs;
    rst       = v.rst;
    src_valid = v.valid;
    src_head  = v.head;
    src_tail  = v.tail;
    src_pl    = v.pl;
    full_in   = v.full;
    for (int i = 0; i < NSRC; i++) src_data[i*DW +: DW] = {v.tag, 16'h0, 8'(i)};
    #1;
    check($sformatf("%s.ready", id), 32'(src_ready), 32'(v.e_ready));
    @(posedge clk);
    #1;
    obs = '{head: out_head, tail: out_tail, pl: out_pl, data: out_data};
    check($sformatf("%s.valid", id), 32'(out_valid), 32'(v.e_valid));
    check($sformatf("%s.err", id), 32'(err_len), 32'(v.e_err));
    if (v.e_valid) begin
      check($sformatf("%s.head", id), 32'(obs.head), 32'(v.e_head));
      check($sformatf("%s.tail", id), 32'(obs.tail), 32'(v.e_tail));
      check($sformatf("%s.pl", id), 32'(obs.pl), 32'(v.e_pl));
      check($sformatf("%s.src", id), 32'(out_src), 32'(v.e_src));
      check($sformatf("%s.data", id), obs.data, {v.e_tag, 16'h0, 6'h0, v.e_src});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t rst_v, idle_v;
    rst_v  = mk(1, 4'hF, 4'hF, 4'hF, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 0);
    idle_v = mk(0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 0);

    // Reset state, then single 3-flit packet from src0; rr_ptr=1 shows as
    // src1 winning over src0 on the next simultaneous heads.
    tbl.push_back(rst_v);
    tbl.push_back(rst_v);
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 8'h01, 1, 1, 1, 0, 0, 0, 8'h01, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 8'h02, 1, 1, 0, 0, 0, 0, 8'h02, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 8'h03, 1, 1, 0, 1, 0, 0, 8'h03, 0));
    tbl.push_back(idle_v);
    tbl.push_back(mk(0, 3, 3, 3, 0, 0, 8'h05, 2, 1, 1, 1, 0, 1, 8'h05, 0));
    tbl.push_back(idle_v);
    // Fairness: four continuous single-flit heads.
    tbl.push_back(rst_v);
    tbl.push_back(mk(0, 4'hF, 4'hF, 4'hF, 0, 0, 8'h10, 1, 1, 1, 1, 0, 0, 8'h10, 0));
    tbl.push_back(mk(0, 4'hF, 4'hF, 4'hF, 0, 0, 8'h11, 2, 1, 1, 1, 0, 1, 8'h11, 0));
    tbl.push_back(mk(0, 4'hF, 4'hF, 4'hF, 0, 0, 8'h12, 4, 1, 1, 1, 0, 2, 8'h12, 0));
    tbl.push_back(mk(0, 4'hF, 4'hF, 4'hF, 0, 0, 8'h13, 8, 1, 1, 1, 0, 3, 8'h13, 0));
    tbl.push_back(mk(0, 4'hF, 4'hF, 4'hF, 0, 0, 8'h14, 1, 1, 1, 1, 0, 0, 8'h14, 0));
    tbl.push_back(idle_v);
    // Lock: src1 4-flit packet, src2 head waiting from the second cycle.
    tbl.push_back(rst_v);
    tbl.push_back(mk(0, 2, 2, 0, 4, 0, 8'h20, 2, 1, 1, 0, 0, 1, 8'h20, 0));
    tbl.push_back(mk(0, 6, 4, 0, 4, 0, 8'h21, 2, 1, 0, 0, 0, 1, 8'h21, 0));
    tbl.push_back(mk(0, 6, 4, 0, 4, 0, 8'h22, 2, 1, 0, 0, 0, 1, 8'h22, 0));
    tbl.push_back(mk(0, 6, 4, 2, 4, 0, 8'h23, 2, 1, 0, 1, 0, 1, 8'h23, 0));
    tbl.push_back(mk(0, 4, 4, 4, 4, 0, 8'h24, 4, 1, 1, 1, 1, 2, 8'h24, 0));
    tbl.push_back(idle_v);
    // Reset mid-packet, then a fresh head from src0.
    tbl.push_back(rst_v);
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 8'h50, 1, 1, 1, 0, 0, 0, 8'h50, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 8'h51, 0, 0, 0, 0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 8'h52, 1, 1, 1, 0, 0, 0, 8'h52, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 8'h53, 1, 1, 0, 1, 0, 0, 8'h53, 0));
    tbl.push_back(idle_v);

    foreach (tbl[i]) apply(tbl[i], $sformatf("t%0d", i));

    // Back-pressure on pl=1 from src3; full_in[0] is ignored for this packet.
    apply(rst_v, "bp_rst");
    apply(mk(0, 8, 8, 0, 8, 0, 8'h30, 8, 1, 1, 0, 1, 3, 8'h30, 0), "bp0");
    apply(mk(0, 8, 0, 0, 8, 1, 8'h31, 8, 1, 0, 0, 1, 3, 8'h31, 0), "bp1");
    for (int k = 0; k < 4; k++)
      apply(mk(0, 8, 0, 0, 8, 2, 8'h32, 0, 1, 0, 0, 1, 3, 8'h31, 0), $sformatf("bp_hold%0d", k));
    apply(mk(0, 8, 0, 0, 8, 0, 8'h32, 8, 1, 0, 0, 1, 3, 8'h32, 0), "bp2");
    apply(mk(0, 8, 0, 8, 8, 0, 8'h33, 8, 1, 0, 1, 1, 3, 8'h33, 0), "bp3");
    apply(idle_v, "bp_idle");

    // Length guard: 6 tail-less flits from src0, forced tail on the 4th.
    apply(rst_v, "len_rst");
    apply(mk(0, 1, 1, 0, 0, 0, 8'h40, 1, 1, 1, 0, 0, 0, 8'h40, 0), "len0");
    for (int k = 1; k < 3; k++)
      apply(mk(0, 1, 0, 0, 0, 0, 8'h40 + 8'(k), 1, 1, 0, 0, 0, 0, 8'h40 + 8'(k), 0),
            $sformatf("len%0d", k));
    apply(mk(0, 1, 0, 0, 0, 0, 8'h43, 1, 1, 0, 1, 0, 0, 8'h43, 1), "len3");
    for (int k = 4; k < 6; k++)
      apply(mk(0, 1, 0, 0, 0, 0, 8'h44, 0, 0, 0, 0, 0, 0, 8'h00, 1), $sformatf("len%0d", k));
    apply(mk(0, 1, 1, 1, 0, 0, 8'h46, 1, 1, 1, 1, 0, 0, 8'h46, 1), "len_new");
    apply(mk(0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 1), "len_idle");
    apply(rst_v, "len_clr");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
